// File: rtl/img_seq_pkg.sv
// Shared types and constants for the image stream sequencer.
package img_seq_pkg;

  localparam int TAG_W   = 3;
  localparam int TAG_SOF = 0;
  localparam int TAG_EOL = 1;
  localparam int TAG_EOF = 2;

  // FSM encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_CAPT   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  // Bit order matches TAG_SOF/TAG_EOL/TAG_EOF
  typedef struct packed {
    logic eof;
    logic eol;
    logic sof;
  } tag_t;

endpackage

// File: rtl/img_stream_sequencer_fifo.sv
// Small synchronous FIFO with occupancy count; flush empties it in one cycle.
module stream_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign empty   = (count == '0);
  assign wr_ok   = wr_en && (count != CW'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/img_stream_sequencer.sv
// Drives the pixel source: header fetch, per-pixel requests with credit
// flow control and horizontal blanking, SOF/EOL/EOF tagging, output buffer.
module img_stream_sequencer
  import img_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int HBLANK_CYC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    src_en,
  input  logic [DATA_WIDTH*3-1:0] src_data,
  input  logic                    src_valid,
  input  logic [15:0]             src_width,
  input  logic [15:0]             src_high,
  input  logic [31:0]             src_frames,
  output logic [DATA_WIDTH*3-1:0] out_data,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             cfg_width,
  output logic [15:0]             cfg_high,
  output logic [31:0]             cfg_frames,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int PW = DATA_WIDTH * 3;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]      state;
  logic [1:0]      hdr_cnt;
  logic [15:0]     x, y;
  logic [31:0]     frame;
  logic [7:0]      blank_cnt;
  logic            req_q;
  tag_t            tag_q, req_tag;
  logic            last_req, credit_ok, hdr_zero;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [PW+TAG_W-1:0] rd_data;

  // Tags of the pixel being requested this cycle
  always_comb begin
    req_tag     = '0;
    req_tag.sof = (x == 16'd0) && (y == 16'd0);
    req_tag.eol = (x == cfg_width - 16'd1);
    req_tag.eof = req_tag.eol && (y == cfg_high - 16'd1);
  end

  assign last_req  = req_tag.eof && (frame == cfg_frames - 32'd1);
  // A request in flight already owns a FIFO slot, so count it as a credit
  assign credit_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, req_q}) < (CW+1)'(FIFO_DEPTH);
  assign hdr_zero  = (src_width == '0) || (src_high == '0) || (src_frames == '0);

  // Source enable: header burst, then credit- and blank-gated pixel requests
  always_comb begin
    src_en = 1'b0;
    case (state)
      S_HDR:    src_en = 1'b1;
      S_ACTIVE: src_en = (blank_cnt == 8'd0) && credit_ok;
      default:  src_en = 1'b0;
    endcase
  end

  // Control FSM, raster counters, blanking and request pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hdr_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      frame      <= '0;
      blank_cnt  <= '0;
      req_q      <= 1'b0;
      tag_q      <= '0;
      cfg_width  <= '0;
      cfg_high   <= '0;
      cfg_frames <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        req_q     <= 1'b0;
        blank_cnt <= '0;
      end else begin
        req_q <= (state == S_ACTIVE) && src_en;
        if ((state == S_ACTIVE) && src_en) tag_q <= req_tag;
        if (req_q && !src_valid) err <= 1'b1;
        case (state)
          S_IDLE: if (start) begin
            state   <= S_HDR;
            hdr_cnt <= '0;
            err     <= 1'b0;
          end
          S_HDR: begin
            hdr_cnt <= hdr_cnt + 1'b1;
            if (hdr_cnt == 2'd2) state <= S_CAPT;
          end
          S_CAPT: begin
            cfg_width  <= src_width;
            cfg_high   <= src_high;
            cfg_frames <= src_frames;
            x          <= '0;
            y          <= '0;
            frame      <= '0;
            blank_cnt  <= '0;
            if (hdr_zero) begin
              err   <= 1'b1;
              state <= S_DRAIN;
            end else begin
              state <= S_ACTIVE;
            end
          end
          S_ACTIVE: begin
            if (blank_cnt != 8'd0) blank_cnt <= blank_cnt - 8'd1;
            if (src_en) begin
              if (req_tag.eol) begin
                x <= '0;
                if (req_tag.eof) begin
                  y     <= '0;
                  frame <= frame + 32'd1;
                end else begin
                  y <= y + 16'd1;
                end
                if (last_req) state <= S_DRAIN;
                else          blank_cnt <= 8'(HBLANK_CYC);
              end else begin
                x <= x + 16'd1;
              end
            end
          end
          S_DRAIN: if (!req_q && fifo_empty) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  stream_fifo #(.W(PW + TAG_W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .wr_en   (req_q),
    .wr_data ({src_data, tag_q}),
    .rd_en   (out_valid && out_ready),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = rd_data[PW+TAG_W-1:TAG_W];
  assign out_sof   = rd_data[TAG_SOF];
  assign out_eol   = rd_data[TAG_EOL];
  assign out_eof   = rd_data[TAG_EOF];
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_img_stream_sequencer.sv
// Directed bench: DUT a has no blanking, DUT b has 3 blank cycles per line.
module tb_img_stream_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT a (HBLANK_CYC=0) ----------------
  logic        start_a, abort_a, src_en_a, src_valid_a, ov_a, rdy_a;
  logic [23:0] src_data_a, out_data_a, scnt_a;
  logic [15:0] w_a, h_a, cfgw_a, cfgh_a;
  logic [31:0] f_a, cfgf_a;
  logic        sof_a, eol_a, eof_a, busy_a, done_a, err_a;
  logic        tog_a, tog_ph, rdy_set;
  int          en_a, done_n_a;
  logic [26:0] q_a[$];

  assign rdy_a = tog_a ? tog_ph : rdy_set;
  always @(posedge clk) tog_ph <= ~tog_ph;

  img_stream_sequencer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .HBLANK_CYC(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .src_en(src_en_a),
    .src_data(src_data_a), .src_valid(src_valid_a), .src_width(w_a), .src_high(h_a),
    .src_frames(f_a), .out_data(out_data_a), .out_sof(sof_a), .out_eol(eol_a),
    .out_eof(eof_a), .out_valid(ov_a), .out_ready(rdy_a), .cfg_width(cfgw_a),
    .cfg_high(cfgh_a), .cfg_frames(cfgf_a), .busy(busy_a), .done(done_a), .err(err_a));

  // Source model: next sequence value appears the cycle after each src_en
  always @(posedge clk or posedge rst)
    if (rst) begin scnt_a <= 0; src_data_a <= 0; src_valid_a <= 0; end
    else if (start_a) scnt_a <= 0;
    else if (src_en_a) begin src_data_a <= scnt_a; scnt_a <= scnt_a + 1; src_valid_a <= 1; end

  always @(negedge clk)
    if (!rst) begin
      if (start_a) begin q_a.delete(); en_a = 0; done_n_a = 0; end
      if (ov_a && rdy_a) q_a.push_back({out_data_a, eof_a, eol_a, sof_a});
      if (done_a) done_n_a++;
      if (src_en_a) en_a++;
    end

  // ---------------- DUT b (HBLANK_CYC=3) ----------------
  logic        start_b, src_en_b, src_valid_b, ov_b;
  logic [23:0] src_data_b, out_data_b, scnt_b;
  logic [15:0] cfgw_b, cfgh_b;
  logic [31:0] cfgf_b;
  logic        sof_b, eol_b, eof_b, busy_b, done_b, err_b;
  int          done_n_b, cyc;
  int          qe_b[$];
  logic [26:0] q_b[$];

  img_stream_sequencer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .HBLANK_CYC(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .src_en(src_en_b),
    .src_data(src_data_b), .src_valid(src_valid_b), .src_width(16'd4), .src_high(16'd2),
    .src_frames(32'd1), .out_data(out_data_b), .out_sof(sof_b), .out_eol(eol_b),
    .out_eof(eof_b), .out_valid(ov_b), .out_ready(1'b1), .cfg_width(cfgw_b),
    .cfg_high(cfgh_b), .cfg_frames(cfgf_b), .busy(busy_b), .done(done_b), .err(err_b));

  always @(posedge clk or posedge rst)
    if (rst) begin scnt_b <= 0; src_data_b <= 0; src_valid_b <= 0; cyc <= 0; end
    else begin
      cyc <= cyc + 1;
      if (start_b) scnt_b <= 0;
      else if (src_en_b) begin src_data_b <= scnt_b; scnt_b <= scnt_b + 1; src_valid_b <= 1; end
    end

  always @(negedge clk)
    if (!rst) begin
      if (start_b) begin q_b.delete(); qe_b.delete(); done_n_b = 0; end
      if (ov_b) q_b.push_back({out_data_b, eof_b, eol_b, sof_b});
      if (done_b) done_n_b++;
      if (src_en_b) qe_b.push_back(cyc);
    end

  // Expected pixel k of a WxH raster: data k+3 (3 header words come first)
  function automatic logic [26:0] exp_pix(input int k, input int w, input int h);
    int   x, y;
    logic s, l, e;
    x = k % w;
    y = (k / w) % h;
    s = (x == 0) && (y == 0);
    l = (x == w - 1);
    e = l && (y == h - 1);
    return {24'(k + 3), e, l, s};
  endfunction

  task automatic run_a(input int w, input int h, input int f, input string tag);
    w_a = 16'(w); h_a = 16'(h); f_a = 32'(f);
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int i = 0; i < 3000 && done_n_a == 0; i++) @(negedge clk);
    chk({tag, "_done_seen"}, 64'(done_n_a != 0), 1);
    repeat (4) @(negedge clk);
    chk({tag, "_done_once"}, 64'(done_n_a), 1);
    chk({tag, "_busy_end"}, 64'(busy_a), 0);
  endtask

  task automatic check_pix_a(input int w, input int h, input int f, input string tag);
    chk({tag, "_npix"}, 64'(q_a.size()), 64'(w * h * f));
    for (int k = 0; k < w * h * f && k < q_a.size(); k++)
      chk({tag, "_pix", $sformatf("%0d", k)}, 64'(q_a[k]), 64'(exp_pix(k, w, h)));
  endtask

  initial begin
    rst = 1; start_a = 0; abort_a = 0; start_b = 0; tog_a = 0; tog_ph = 0; rdy_set = 1;
    w_a = 0; h_a = 0; f_a = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(ov_a), 0);
    chk("rst_src_en", 64'(src_en_a), 0);
    chk("rst_busy", 64'(busy_a), 0);
    chk("rst_done", 64'(done_a), 0);
    chk("rst_err", 64'(err_a), 0);
    chk("rst_cfg", {cfgf_a, cfgw_a, cfgh_a}, 0);
    chk("rst_data", 64'({out_data_a, sof_a, eol_a, eof_a}), 0);
    @(posedge clk); #1 rst = 0;

    // 4x2x1, ready held high
    run_a(4, 2, 1, "t1");
    check_pix_a(4, 2, 1, "t1");
    chk("t1_cfg", {cfgf_a, cfgw_a, cfgh_a}, {32'd1, 16'd4, 16'd2});
    chk("t1_err", 64'(err_a), 0);

    // Same image, ready alternating each cycle
    tog_a = 1;
    run_a(4, 2, 1, "t2");
    check_pix_a(4, 2, 1, "t2");
    tog_a = 0;

    // Two frames of 3x2
    run_a(3, 2, 2, "t3");
    check_pix_a(3, 2, 2, "t3");

    // Zero width header: error, header fetch only, done still pulses
    run_a(0, 2, 1, "t4");
    chk("t4_err", 64'(err_a), 1);
    chk("t4_npix", 64'(q_a.size()), 0);
    chk("t4_src_en_cycles", 64'(en_a), 3);

    // A fresh start clears the error
    run_a(4, 2, 1, "t5");
    chk("t5_err_clr", 64'(err_a), 0);
    check_pix_a(4, 2, 1, "t5");

    // Abort mid-frame with the sink stalled
    rdy_set = 0;
    w_a = 16'd4; h_a = 16'd2; f_a = 32'd1;
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int i = 0; i < 200 && en_a < 6; i++) @(negedge clk);
    chk("t6_reached_px2", 64'(en_a >= 6), 1);
    @(posedge clk); #1 abort_a = 1;
    @(posedge clk); #1 abort_a = 0;
    @(negedge clk);
    chk("t6_busy", 64'(busy_a), 0);
    chk("t6_valid", 64'(ov_a), 0);
    chk("t6_src_en", 64'(src_en_a), 0);
    repeat (5) @(negedge clk);
    chk("t6_no_done", 64'(done_n_a), 0);
    chk("t6_err_kept", 64'(err_a), 0);
    chk("t6_cfg_kept", 64'(cfgw_a), 4);
    rdy_set = 1;

    // Horizontal blanking on DUT b
    @(posedge clk); #1 start_b = 1;
    @(posedge clk); #1 start_b = 0;
    for (int i = 0; i < 3000 && done_n_b == 0; i++) @(negedge clk);
    chk("hb_done_seen", 64'(done_n_b != 0), 1);
    repeat (4) @(negedge clk);
    chk("hb_done_once", 64'(done_n_b), 1);
    chk("hb_src_en_total", 64'(qe_b.size()), 11);
    if (qe_b.size() >= 11) begin
      chk("hb_gap_p0_p1", 64'(qe_b[4] - qe_b[3]), 1);
      chk("hb_gap_p3_p4", 64'(qe_b[7] - qe_b[6]), 4);
      chk("hb_gap_p6_p7", 64'(qe_b[10] - qe_b[9]), 1);
    end else chk("hb_gap_short", 64'(qe_b.size()), 11);
    chk("hb_npix", 64'(q_b.size()), 8);
    for (int k = 0; k < 8 && k < q_b.size(); k++)
      chk($sformatf("hb_pix%0d", k), 64'(q_b[k]), 64'(exp_pix(k, 4, 2)));
    chk("hb_cfg", {cfgf_b, cfgw_b, cfgh_b}, {32'd1, 16'd4, 16'd2});
    chk("hb_status", 64'({busy_b, err_b}), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
